alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Request/response front end that drives the datapath ALU's operand and control port and collects its result. Upstream logic submits a tagged operation (operands plus a 3-bit opcode) over a valid/ready handshake. The block maps the opcode to the 4-bit ALU control code, presents the operands on registered outputs, and captures the ALU's result, overflow and zero flags. Results return in order through a response FIFO with its own valid/ready handshake.

## Interface
- INTERNAL_BITS, 16, operand/result width; the ALU result port is INTERNAL_BITS+1 wide.
- FIFO_DEPTH, 4, response FIFO entries; power of two, minimum 2.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
- req_op  input  3  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6 NOR, 7 illegal.
- req_a, req_b  input  INTERNAL_BITS  operands.
- req_tag  input  4  opaque tag, echoed on the response.
- alu_src1, alu_src2  output  INTERNAL_BITS  registered operands to the ALU.
- alu_ctrl  output  4  registered ALU control code.
- alu_result  input  INTERNAL_BITS+1  ALU result; the MSB is the overflow bit.
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response valid (FIFO head).
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  output  INTERNAL_BITS  result.
- rsp_ovf  output  1  signed overflow; ADD and SUB only.
- rsp_zero  output  1  result equals zero.
- rsp_err  output  1  illegal opcode (or trapped overflow, see Configuration).
- rsp_tag  output  4  echoed tag.

## Operation
- **Opcode map to alu_ctrl:** AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, SLT 4'b0111, MUL 4'b1000, NOR 4'b1100.
- **Illegal opcode 7:** alu_ctrl=4'b0000 and both operands driven 0. The response is err=1, data=0, ovf=0, zero=0.
- **Issue stage registers:** alu_src1, alu_src2, alu_ctrl, an issue_valid flag, the tag and an illegal flag. They load on request acceptance.
- **Issue stage with no acceptance:** issue_valid clears, and the operand/control outputs hold their last values.
- **Capture:** when issue_valid=1, the FIFO pushes the following fields at the next edge.
  - data = alu_result[INTERNAL_BITS-1:0].
  - ovf = alu_result[INTERNAL_BITS], for ADD and SUB only; 0 for all other ops.
  - zero = alu_zero for SUB; for all other ops, (data == 0) computed locally.
- **Flow control:** req_ready = (fifo_count + issue_valid) < FIFO_DEPTH.
  - This is credit-based, so the FIFO never overflows.
  - There is no combinational path from rsp_ready to req_ready.
- **FIFO:** read/write pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves fifo_count unchanged. A push into a full FIFO is impossible by construction.
- **Ordering:** responses leave strictly in acceptance order.

## Timing
- **Reset values** (rst_n low, asynchronous): alu_src1=0, alu_src2=0, alu_ctrl=0, issue_valid=0, FIFO empty, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_zero=0, rsp_err=0, rsp_tag=0.
- **req_ready** is combinational and reads 1 from reset onward.
- **Reset mid-operation** discards any in-flight issue and all FIFO contents. No response is produced for them.
- **Latency:** a request accepted at edge E0 drives the ALU during cycle E0..E1 and is pushed at E1. With an empty FIFO, rsp_valid=1 immediately after E1 (2 edges).
- **Throughput:** one request per cycle while rsp_ready stays high.
- **Backpressure:** with rsp_ready held low, exactly FIFO_DEPTH requests are accepted, then req_ready=0.
  - req_ready returns to 1 in the cycle after the first pop.
- **Head stability:** rsp_* fields are stable while rsp_valid && !rsp_ready.

## Configuration
- **ALU_OVF_TRAP_EN defined:** a response with ovf=1 is stored with err=1 and data=0; rsp_ovf stays 1.
- **ALU_OVF_TRAP_EN undefined:** data passes through unchanged and err reflects the illegal opcode only.
- No other behaviour differs between the two builds.

## Test plan
- **ADD overflow:** ADD 0x7FFF+0x0001, tag 3, bench ALU returns 17'h18000 -> rsp_data=0x8000, ovf=1, err=0 (trap off), tag=3, rsp_valid 2 edges after acceptance.
- **SUB zero:** SUB 0x0005-0x0005, alu_zero=1 -> data=0x0000, zero=1, ovf=0, alu_ctrl observed as 4'b0110.
- **Illegal opcode:** op 7, a=0x1234 -> alu_src1=0, alu_ctrl=0; response err=1, data=0, tag echoed.
- **Backpressure and ordering:** rsp_ready=0, offer 5 back-to-back requests with tags 0..4 -> 4 accepted, req_ready=0. Raise rsp_ready -> tags 0,1,2,3 drain in order, then tag 4 is accepted and returned.
- **Reset mid-operation:** assert rst_n low while 2 entries are queued and 1 is in flight -> rsp_valid=0 immediately; after release no stale response appears and req_ready=1.
- **Trap build (ALU_OVF_TRAP_EN defined):** repeat the ADD overflow case -> data=0, err=1, ovf=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request/response front end for the datapath ALU.
// Requests (operands + 3-bit opcode + tag) are registered onto the ALU port, the ALU result is
// captured one cycle later into an in-order response FIFO. Flow control is credit based so
// the FIFO can never overflow.
// Optional build macro: ALU_OVF_TRAP_EN -- overflowing ADD/SUB results are stored as errors
// with data forced to zero (rsp_ovf still reports the overflow).
module alu_issue_ctrl #(
  parameter int unsigned INTERNAL_BITS = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // Request side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [INTERNAL_BITS-1:0] req_a,
  input  logic [INTERNAL_BITS-1:0] req_b,
  input  logic [3:0]               req_tag,
  // ALU port
  output logic [INTERNAL_BITS-1:0] alu_src1,
  output logic [INTERNAL_BITS-1:0] alu_src2,
  output logic [3:0]               alu_ctrl,
  input  logic [INTERNAL_BITS:0]   alu_result,
  input  logic                     alu_zero,
  // Response side
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INTERNAL_BITS-1:0] rsp_data,
  output logic                     rsp_ovf,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic [3:0]               rsp_tag
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INTERNAL_BITS-1:0] data;
    logic                     ovf;
    logic                     zero;
    logic                     err;
    logic [3:0]               tag;
  } rsp_entry_t;

  // Issue stage state
  logic [INTERNAL_BITS-1:0] src1_q, src2_q;
  logic [3:0]               ctrl_q;
  logic                     issue_valid_q;
  logic [3:0]               tag_q;
  logic                     illegal_q;
  logic                     addsub_q;
  logic                     sub_q;

  // Decoded request
  logic [3:0] ctrl_d;
  logic       illegal_d;
  logic       addsub_d;
  logic       sub_d;
  logic       req_fire;

  // Response FIFO state
  rsp_entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [CntW:0]         credits;
  logic                  push, pop;
  rsp_entry_t            cap;
  rsp_entry_t            head;

  // Outstanding work = queued responses plus the one on the ALU this cycle.
  assign credits   = {1'b0, count_q} + {{CntW{1'b0}}, issue_valid_q};
  assign req_ready = credits < (CntW + 1)'(FIFO_DEPTH);
  assign req_fire  = req_valid && req_ready;

  // Map the opcode to the ALU control code and classify it for the capture stage.
  always_comb begin
    ctrl_d    = 4'b0000;
    illegal_d = 1'b0;
    addsub_d  = 1'b0;
    sub_d     = 1'b0;
    unique case (req_op)
      3'd0: ctrl_d = 4'b0000;
      3'd1: ctrl_d = 4'b0001;
      3'd2: begin ctrl_d = 4'b0010; addsub_d = 1'b1; end
      3'd3: begin ctrl_d = 4'b0110; addsub_d = 1'b1; sub_d = 1'b1; end
      3'd4: ctrl_d = 4'b0111;
      3'd5: ctrl_d = 4'b1000;
      3'd6: ctrl_d = 4'b1100;
      3'd7: illegal_d = 1'b1;
    endcase
  end

  // Issue registers: load on acceptance, otherwise hold operands and drop issue_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1_q        <= '0;
      src2_q        <= '0;
      ctrl_q        <= '0;
      issue_valid_q <= 1'b0;
      tag_q         <= '0;
      illegal_q     <= 1'b0;
      addsub_q      <= 1'b0;
      sub_q         <= 1'b0;
    end else if (req_fire) begin
      src1_q        <= illegal_d ? '0 : req_a;
      src2_q        <= illegal_d ? '0 : req_b;
      ctrl_q        <= ctrl_d;
      issue_valid_q <= 1'b1;
      tag_q         <= req_tag;
      illegal_q     <= illegal_d;
      addsub_q      <= addsub_d;
      sub_q         <= sub_d;
    end else begin
      issue_valid_q <= 1'b0;
    end
  end

  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;
  assign alu_ctrl = ctrl_q;

  // Build the response entry from the ALU outputs of the instruction in flight.
  always_comb begin
    cap     = '0;
    cap.tag = tag_q;
    if (illegal_q) begin
      cap.err = 1'b1;
    end else begin
      cap.data = alu_result[INTERNAL_BITS-1:0];
      cap.ovf  = addsub_q & alu_result[INTERNAL_BITS];
      // Only SUB trusts the ALU zero flag; other ops derive it from the data.
      cap.zero = sub_q ? alu_zero : (alu_result[INTERNAL_BITS-1:0] == '0);
    end
`ifdef ALU_OVF_TRAP_EN
    if (cap.ovf) begin
      cap.data = '0;
      cap.err  = 1'b1;
    end
`endif
  end

  assign push = issue_valid_q;
  assign pop  = rsp_valid && rsp_ready;

  // Response FIFO storage and pointers; credits guarantee push never hits a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cap;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Present the head entry; zeros when empty so stale data never leaks out.
  always_comb begin
    rsp_valid = (count_q != '0);
    head      = rsp_valid ? mem_q[rd_ptr_q] : '0;
    rsp_data  = head.data;
    rsp_ovf   = head.ovf;
    rsp_zero  = head.zero;
    rsp_err   = head.err;
    rsp_tag   = head.tag;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the expected responses. The bench also plays the ALU.
module tb_alu_issue_ctrl;

`ifdef ALU_OVF_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [15:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [16:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_ovf, rsp_zero, rsp_err;
  logic [3:0]  rsp_tag;

  int checks = 0;
  int errors = 0;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  logic junk_msb = 1'b0;
  logic junk_zero = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.INTERNAL_BITS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  // External ALU: junk in the overflow bit / zero flag where the block must ignore them.
  logic [15:0] alu_r;
  logic        alu_v;
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_r = alu_src1 & alu_src2;
      4'b0001: alu_r = alu_src1 | alu_src2;
      4'b0010: begin
        alu_r = alu_src1 + alu_src2;
        alu_v = (alu_src1[15] == alu_src2[15]) && (alu_r[15] != alu_src1[15]);
      end
      4'b0110: begin
        alu_r = alu_src1 - alu_src2;
        alu_v = (alu_src1[15] != alu_src2[15]) && (alu_r[15] != alu_src1[15]);
      end
      4'b0111: alu_r = ($signed(alu_src1) < $signed(alu_src2)) ? 16'd1 : 16'd0;
      4'b1000: alu_r = alu_src1 * alu_src2;
      4'b1100: alu_r = ~(alu_src1 | alu_src2);
      default: alu_r = 16'hdead;
    endcase
    alu_result = {((alu_ctrl == 4'b0010) || (alu_ctrl == 4'b0110)) ? alu_v : junk_msb, alu_r};
    alu_zero   = (alu_ctrl == 4'b0110) ? (alu_r == 16'd0) : junk_zero;
  end

  // Expected response straight from the opcode semantics.
  function automatic rsp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] tag);
    rsp_t m;
    logic [15:0] d;
    logic v;
    d = '0;
    v = 1'b0;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: begin d = a + b; v = (a[15] == b[15]) && (d[15] != a[15]); end
      3'd3: begin d = a - b; v = (a[15] != b[15]) && (d[15] != a[15]); end
      3'd4: d = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd5: d = a * b;
      3'd6: d = ~(a | b);
      default: d = '0;
    endcase
    m.tag  = tag;
    m.ovf  = v;
    m.err  = (op == 3'd7);
    m.zero = (op != 3'd7) && (d == 16'd0);
    m.data = d;
    if (Trap && v) begin
      m.data = '0;
      m.err  = 1'b1;
    end
    return m;
  endfunction

  // Record accepted requests and consumed responses as seen at each rising edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) exp_q.push_back(model(req_op, req_a, req_b, req_tag));
      if (rsp_valid && rsp_ready) obs_q.push_back({rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag});
    end
  end

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h7fff;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction

  // Wait (bounded) until the given number of responses has been consumed.
  task automatic drain(input int want, output bit ok);
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (obs_q.size() >= want) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    checks++; if (alu_src1 !== 16'd0 || alu_src2 !== 16'd0) begin errors++;
      $display("FAIL reset_src got %h/%h want 0/0", alu_src1, alu_src2); end
    checks++; if (alu_ctrl !== 4'd0) begin errors++;
      $display("FAIL reset_ctrl got %h want 0", alu_ctrl); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag} !== 23'd0) begin errors++;
      $display("FAIL reset_rsp_fields got %h/%b/%b/%b/%h want 0", rsp_data, rsp_ovf, rsp_zero,
               rsp_err, rsp_tag); end
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_req_ready got %b want 1", req_ready); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL post_reset got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_add_ovf();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd2; req_a = 16'h7fff; req_b = 16'h0001; req_tag = 4'd3;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL add_ready got %b want 1", req_ready); end
    @(posedge clk); #1;  // accepted at this edge
    req_valid = 1'b0;
    checks++; if (alu_ctrl !== 4'b0010 || alu_src1 !== 16'h7fff || alu_src2 !== 16'h0001) begin
      errors++; $display("FAIL add_issue got ctrl=%h a=%h b=%h want 2/7fff/0001", alu_ctrl,
                         alu_src1, alu_src2); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL add_early_valid got %b want 0", rsp_valid); end
    @(posedge clk); #1;  // pushed at this edge
    checks++; if (rsp_valid !== 1'b1) begin errors++;
      $display("FAIL add_latency got valid=%b want 1", rsp_valid); end
    checks++; if (rsp_data !== (Trap ? 16'h0000 : 16'h8000) || rsp_ovf !== 1'b1 ||
                  rsp_err !== Trap || rsp_tag !== 4'd3 || rsp_zero !== 1'b0) begin errors++;
      $display("FAIL add_ovf_rsp got d=%h o=%b e=%b t=%h z=%b want d=%h o=1 e=%b t=3 z=0",
               rsp_data, rsp_ovf, rsp_err, rsp_tag, rsp_zero, Trap ? 16'h0 : 16'h8000, Trap); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_zero();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd3; req_a = 16'h0005; req_b = 16'h0005; req_tag = 4'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (alu_ctrl !== 4'b0110) begin errors++;
      $display("FAIL sub_ctrl got %h want 6", alu_ctrl); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_zero !== 1'b1 ||
                  rsp_ovf !== 1'b0 || rsp_err !== 1'b0 || rsp_tag !== 4'd9) begin errors++;
      $display("FAIL sub_zero_rsp got v=%b d=%h z=%b o=%b e=%b t=%h want 1/0/1/0/0/9",
               rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err, rsp_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
    junk_msb = 1'b1; junk_zero = 1'b1;
    req_valid = 1'b1; req_op = 3'd7; req_a = 16'h1234; req_b = 16'h5678; req_tag = 4'd12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (alu_src1 !== 16'h0 || alu_src2 !== 16'h0 || alu_ctrl !== 4'h0) begin errors++;
      $display("FAIL illegal_issue got a=%h b=%h ctrl=%h want 0/0/0", alu_src1, alu_src2,
               alu_ctrl); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 ||
                  rsp_ovf !== 1'b0 || rsp_zero !== 1'b0 || rsp_tag !== 4'd12) begin errors++;
      $display("FAIL illegal_rsp got v=%b e=%b d=%h o=%b z=%b t=%h want 1/1/0/0/0/c",
               rsp_valid, rsp_err, rsp_data, rsp_ovf, rsp_zero, rsp_tag); end
    junk_msb = 1'b0; junk_zero = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rsp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_op = 3'($urandom_range(0, 6));
      req_a = pick_operand(); req_b = pick_operand(); req_tag = 4'(i);
      if (req_ready === 1'b1) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++; if (acc != 8) begin errors++;
      $display("FAIL b2b_throughput got %0d accepts want 8", acc); end
    drain(8, ok);
    checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL b2b_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    bit ok;
    exp_q.delete(); obs_q.delete();
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_op = 3'd2; req_a = 16'($urandom); req_b = 16'($urandom);
      req_tag = 4'(acc);
      if (req_ready === 1'b1) acc++;
      @(posedge clk); #1;
    end
    req_op = 3'd2; req_tag = 4'(acc);
    checks++; if (acc != 4) begin errors++;
      $display("FAIL bp_accepts got %0d want 4", acc); end
    checks++; if (req_ready !== 1'b0) begin errors++;
      $display("FAIL bp_ready_low got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0) begin errors++;
      $display("FAIL bp_head got v=%b t=%h want 1/0", rsp_valid, rsp_tag); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;  // first pop
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL bp_ready_return got %b want 1", req_ready); end
    for (int c = 0; c < 20 && acc < 5; c++) begin
      if (req_ready === 1'b1) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain(5, ok);
    checks++; if (!ok || obs_q.size() != 5 || exp_q.size() != 5) begin errors++;
      $display("FAIL bp_count got %0d/%0d want 5/5", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (obs_q[i] !== exp_q[i] || obs_q[i].tag !== 4'(i)) begin errors++;
        $display("FAIL bp_order[%0d] got %h want %h tag %0d", i, obs_q[i], exp_q[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_op = 3'd1; req_a = 16'h00f0; req_b = 16'h0f00; req_tag = 4'(10 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++;
      $display("FAIL rmid_pre got valid=%b want 1", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL rmid_async got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen || obs_q.size() != 0) begin errors++;
      $display("FAIL rmid_stale got seen=%b pops=%0d want 0/0", seen, obs_q.size()); end
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL rmid_ready got %b want 1", req_ready); end
  endtask

  task automatic test_random();
    bit   ok;
    bit   stalled;
    rsp_t held;
    exp_q.delete(); obs_q.delete();
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 500; c++) begin
      if (stalled) begin
        checks++; if ({rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag} !== held ||
                      rsp_valid !== 1'b1) begin errors++;
          $display("FAIL rnd_head_stable cycle %0d got %h want %h", c,
                   {rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag}, held); end
      end
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_a     = pick_operand();
      req_b     = pick_operand();
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      junk_msb  = 1'($urandom);
      junk_zero = 1'($urandom);
      stalled   = rsp_valid && !rsp_ready;
      held      = {rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag};
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    drain(exp_q.size(), ok);
    checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rnd_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
